// File: rtl/lfm_pkg.sv
// Shared types and default widths for the LFM sweep controller.
// The LFM_TRIANGLE_EN macro adds the triangle-mode bit to the config record.
package lfm_pkg;

  localparam int N_PHASE  = 32;
  localparam int CNT_W    = 20;
  localparam int NPULSE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHIRP = 2'd1,
    GAP   = 2'd2
  } lfm_state_e;

  // Holding-register image of one accepted configuration.
  typedef struct packed {
    logic [N_PHASE-1:0]  ftw0;
    logic [N_PHASE-1:0]  dftw;
    logic [CNT_W-1:0]    len;
    logic [CNT_W-1:0]    gap;
    logic [NPULSE_W-1:0] npulse;
`ifdef LFM_TRIANGLE_EN
    logic                tri_mode;
`endif
  } lfm_cfg_t;

endpackage

// File: rtl/lfm_sweep_ctrl.sv
// LFM chirp sequencer: ramps a tuning word per sample and frames chirps into
// bursts separated by programmable gaps. Optional macro LFM_TRIANGLE_EN adds
// a cfg_tri input selecting up/down triangle chirps.
// The config record uses the lfm_pkg widths; keep the parameters at their
// package defaults or change both together.
module lfm_sweep_ctrl #(
  parameter int N_PHASE  = lfm_pkg::N_PHASE,
  parameter int CNT_W    = lfm_pkg::CNT_W,
  parameter int NPULSE_W = lfm_pkg::NPULSE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [N_PHASE-1:0]  cfg_ftw0,
  input  logic [N_PHASE-1:0]  cfg_dftw,
  input  logic [CNT_W-1:0]    cfg_len,
  input  logic [CNT_W-1:0]    cfg_gap,
  input  logic [NPULSE_W-1:0] cfg_npulse,
`ifdef LFM_TRIANGLE_EN
  input  logic                cfg_tri,
`endif
  input  logic                start,
  input  logic                abort,
  output logic [N_PHASE-1:0]  ftw,
  output logic                ftw_valid,
  output logic                chirp_start,
  output logic                busy,
  output logic                done
);
  import lfm_pkg::*;

  lfm_cfg_t            cfg_q;
  lfm_cfg_t            cfg_in_s;
  logic                cfg_loaded_q;
  lfm_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;         // samples left in ramp, or gap cycles left
  logic [NPULSE_W-1:0] pulse_left_q;  // chirps left including the current one
  logic                down_q;        // in the falling half of a triangle
  logic [N_PHASE-1:0]  ftw_q;
  logic                ftw_valid_q;
  logic                chirp_start_q;
  logic                busy_q;
  logic                done_q;

  logic                cfg_hs_s;
  logic                go_s;
  logic                last_pulse_s;
  logic                tri_s;
  logic [N_PHASE-1:0]  step_s;
  logic [N_PHASE-1:0]  eff_ftw0_s;
  logic [CNT_W-1:0]    eff_len_s;
  logic [NPULSE_W-1:0] eff_npulse_s;

  assign cfg_ready   = (state_q == IDLE);
  assign cfg_hs_s    = cfg_valid & cfg_ready;
  assign ftw         = ftw_q;
  assign ftw_valid   = ftw_valid_q;
  assign chirp_start = chirp_start_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef LFM_TRIANGLE_EN
  assign tri_s = cfg_q.tri_mode;
`else
  assign tri_s = 1'b0;
`endif

  // Gather the offered fields; a start coinciding with a handshake uses them.
  always_comb begin
    cfg_in_s.ftw0   = cfg_ftw0;
    cfg_in_s.dftw   = cfg_dftw;
    cfg_in_s.len    = cfg_len;
    cfg_in_s.gap    = cfg_gap;
    cfg_in_s.npulse = cfg_npulse;
`ifdef LFM_TRIANGLE_EN
    cfg_in_s.tri_mode = cfg_tri;
`endif
    if (cfg_hs_s) begin
      eff_ftw0_s   = cfg_ftw0;
      eff_len_s    = cfg_len;
      eff_npulse_s = cfg_npulse;
    end else begin
      eff_ftw0_s   = cfg_q.ftw0;
      eff_len_s    = cfg_q.len;
      eff_npulse_s = cfg_q.npulse;
    end
  end

  // Start qualification, end-of-burst test and the signed ramp step.
  always_comb begin
    go_s = start & ~abort & (state_q == IDLE) & (cfg_loaded_q | cfg_hs_s)
         & (eff_len_s != '0);
    last_pulse_s = (cfg_q.npulse != '0) && (pulse_left_q == NPULSE_W'(1));
    if (down_q) begin
      step_s = -cfg_q.dftw;
    end else begin
      step_s = cfg_q.dftw;
    end
  end

  // Configuration holding registers, written only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q        <= '0;
      cfg_loaded_q <= 1'b0;
    end else if (cfg_hs_s) begin
      cfg_q        <= cfg_in_s;
      cfg_loaded_q <= 1'b1;
    end
  end

  // Burst FSM with registered tuning word and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pulse_left_q  <= '0;
      down_q        <= 1'b0;
      ftw_q         <= '0;
      ftw_valid_q   <= 1'b0;
      chirp_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      chirp_start_q <= 1'b0;
      done_q        <= 1'b0;
      if (abort) begin
        state_q      <= IDLE;
        cnt_q        <= '0;
        pulse_left_q <= '0;
        down_q       <= 1'b0;
        ftw_q        <= '0;
        ftw_valid_q  <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (go_s) begin
              state_q       <= CHIRP;
              cnt_q         <= eff_len_s - CNT_W'(1);
              pulse_left_q  <= eff_npulse_s;
              down_q        <= 1'b0;
              ftw_q         <= eff_ftw0_s;
              ftw_valid_q   <= 1'b1;
              chirp_start_q <= 1'b1;
              busy_q        <= 1'b1;
            end
          end
          CHIRP: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_W'(1);
              ftw_q <= ftw_q + step_s;
            end else if (tri_s && !down_q) begin
              // Peak sample is repeated as the first falling sample.
              down_q <= 1'b1;
              cnt_q  <= cfg_q.len - CNT_W'(1);
            end else if (last_pulse_s) begin
              state_q     <= IDLE;
              down_q      <= 1'b0;
              ftw_q       <= '0;
              ftw_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              down_q <= 1'b0;
              if (cfg_q.npulse != '0) begin
                pulse_left_q <= pulse_left_q - NPULSE_W'(1);
              end
              if (cfg_q.gap != '0) begin
                state_q     <= GAP;
                cnt_q       <= cfg_q.gap - CNT_W'(1);
                ftw_q       <= '0;
                ftw_valid_q <= 1'b0;
              end else begin
                cnt_q         <= cfg_q.len - CNT_W'(1);
                ftw_q         <= cfg_q.ftw0;
                chirp_start_q <= 1'b1;
              end
            end
          end
          GAP: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_W'(1);
            end else begin
              state_q       <= CHIRP;
              cnt_q         <= cfg_q.len - CNT_W'(1);
              ftw_q         <= cfg_q.ftw0;
              ftw_valid_q   <= 1'b1;
              chirp_start_q <= 1'b1;
            end
          end
          default: begin
            state_q     <= IDLE;
            ftw_q       <= '0;
            ftw_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/lfm_sweep_ctrl.md
Name: lfm_sweep_ctrl

Overview:
- Upstream sequencer for the LFM DDS stage.
- Emits a per-cycle frequency tuning word (FTW) that ramps linearly during each chirp.
- Frames chirps into a burst of N pulses separated by programmable gaps.
- The downstream phase accumulator consumes `ftw` as its phase increment and clears its phase on `chirp_start`.

Parameters:
- N_PHASE, 32, FTW / phase-increment width.
- CNT_W, 20, width of the chirp-length and gap counters.
- NPULSE_W, 8, width of the pulse-count field.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration accept; high only in IDLE.
- cfg_ftw0  in  N_PHASE  start FTW.
- cfg_dftw  in  N_PHASE  per-cycle FTW increment, two's complement.
- cfg_len  in  CNT_W  chirp length in samples.
- cfg_gap  in  CNT_W  idle cycles between chirps.
- cfg_npulse  in  NPULSE_W  chirps per burst; 0 = continuous.
- start  in  1  burst start request.
- abort  in  1  immediate stop.
- ftw  out  N_PHASE  current tuning word; 0 when not chirping.
- ftw_valid  out  1  high while a chirp sample is driven.
- chirp_start  out  1  one-cycle pulse on the first sample of each chirp.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a finite burst completes.

Behaviour:
- **Reset:** clk, rst_n as named; reset is async assert, sync deassert handled externally. All outputs reset to 0, state = IDLE, `cfg_loaded` = 0, every config register = 0.
- **Config handshake:** accepted when cfg_valid & cfg_ready; all fields are registered and `cfg_loaded` is set. cfg_ready = (state==IDLE). Config never changes mid-burst.
- **States:** IDLE, CHIRP, GAP.
- **IDLE → CHIRP:** start sampled high at cycle T with (cfg_loaded or same-cycle handshake) and len != 0.
  - If the handshake and start coincide, the new config is used.
  - With len == 0, or no config loaded, start is ignored.
- **First chirp sample:** at T+1: ftw = ftw0, ftw_valid = 1, chirp_start = 1.
- **Sample sequence:** sample k (0..len-1) has ftw = ftw0 + k·dftw, computed mod 2^N_PHASE; wrap is silent with no saturation.
- **Datapath:** one registered adder; the sample counter counts len-1 down to 0.
- **After the last sample:**
  - Pulses remain and gap > 0 → GAP for exactly gap cycles, with ftw = 0 and ftw_valid = 0.
  - Pulses remain and gap = 0 → the next chirp's first sample follows directly (back-to-back, chirp_start high, ftw reloaded to ftw0).
  - Last pulse → IDLE; done = 1 in the first IDLE cycle.
- **Continuous mode:** npulse = 0 repeats until abort and never asserts done.
- **start while busy:** ignored.
- **abort:** highest priority in every state. Next cycle: IDLE, ftw = 0, ftw_valid = 0, no done pulse; config is retained.
- **abort and start together in IDLE:** stay in IDLE.
- **Reset mid-burst:** immediate return to reset values; `cfg_loaded` is cleared.
- **busy:** is a registered output.

Optional Feature:
- Macro: LFM_TRIANGLE_EN.
- When defined:
  - An extra port `cfg_tri` (in, 1) is added and registered with the config.
  - With cfg_tri = 1, each chirp is 2·len samples: len up-ramp samples, then len samples stepping down from the peak.
  - Samples are ftw0 + (len-1-j)·dftw for j = 0..len-1, so the peak sample is repeated.
  - chirp_start pulses once per triangle.
- When undefined: sawtooth only; no cfg_tri port.

Decomposition:
- Package `lfm_pkg` holds:
  - the state enum type {IDLE, CHIRP, GAP};
  - default width constants N_PHASE = 32, CNT_W = 20, NPULSE_W = 8;
  - a packed config struct (ftw0, dftw, len, gap, npulse[, tri]).
- No sub-module needed; an optional small `lfm_cfg_regs` (handshake + holding registers) is acceptable.

Test Plan:
1. **Single chirp:** cfg ftw0=100, dftw=5, len=4, gap=0, npulse=1, then start → ftw 100,105,110,115 at T+1..T+4; chirp_start at T+1; done at T+5; busy low at T+5.
2. **Burst with gaps:** len=3, gap=2, npulse=2 → 3 valid, 2 invalid with ftw=0, 3 valid (chirp_start again), then done; 8 busy cycles total.
3. **Wrap and negative ramp:** ftw0=32'hFFFF_FFFE, dftw=1, len=3 → FFFF_FFFE, FFFF_FFFF, 0000_0000. dftw=32'hFFFF_FFFF → descending sequence.
4. **Abort mid-burst:** npulse=0 continuous; abort on the 2nd sample of the 3rd chirp → next cycle IDLE, ftw=0, no done; restart with the retained config works.
5. **Handshake corners:**
   - cfg_valid while busy → cfg_ready=0, config unchanged.
   - Handshake and start in the same cycle → new ftw0 appears at T+1.
   - start with len=0 → no activity.
6. **LFM_TRIANGLE_EN with cfg_tri=1:** ftw0=0, dftw=10, len=3 → 0,10,20,20,10,0; one chirp_start; done after 6 samples.
